vau_inst_sequencer: RTL and testbench

Instruction sequencer directly upstream of the vector ALU in the user project. Accepts 32-bit vector instructions from the management core through a valid/ready port and buffers them in a small FIFO. Decodes each instruction and steps the ALU through reset, operand-A load, operand-B load and element-wise execute. Drives the registered status flags routed to mprj_io[18] (alu reset), mprj_io[16] (operand select) and mprj_io[15:12] (operation).

---
 rtl/vau_pkg.sv | 27 ++
 rtl/vau_inst_sequencer_if.sv | 30 +++
 rtl/vau_sync_fifo.sv | 52 +++++
 rtl/vau_inst_sequencer.sv | 140 ++++++++++++++
 tb/tb_vau_inst_sequencer.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vau_pkg.sv
// Shared opcode, instruction-field and FSM-state constants for the vector ALU sequencer.
package vau_pkg;

  localparam logic [3:0] OP_NOP     = 4'h0;
  localparam logic [3:0] OP_ALU_MIN = 4'h1;
  localparam logic [3:0] OP_ALU_MAX = 4'hA;
  localparam logic [3:0] OP_RESET   = 4'hF;

  localparam int OPC_MSB     = 31;
  localparam int OPC_LSB     = 28;
  localparam int VLEN_MSB    = 27;
  localparam int VLEN_LSB    = 20;
  // Only opcode and vlen are buffered; the reserved low bits never reach the FIFO.
  localparam int INST_KEEP_W = OPC_MSB - VLEN_LSB + 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_RST    = 3'd2;
  localparam logic [2:0] ST_LOAD_A = 3'd3;
  localparam logic [2:0] ST_LOAD_B = 3'd4;
  localparam logic [2:0] ST_EXEC   = 3'd5;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ALU_MIN) && (op <= OP_ALU_MAX);
  endfunction

endpackage

// File: rtl/vau_inst_sequencer_if.sv
// Host instruction port, ALU request port and status flags of the sequencer.
interface vau_inst_sequencer_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int VLEN_W     = 8
);
  logic                          inst_valid;
  logic [31:0]                   inst_data;
  logic                          inst_ready;
  logic                          alu_op_valid;
  logic [VLEN_W-1:0]             alu_elem_idx;
  logic                          alu_ready;
  logic                          flag_alu_rst;
  logic                          flag_operand;
  logic [3:0]                    flag_operation;
  logic                          busy;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          err_illegal;

  modport slave (
    input  inst_valid, inst_data, alu_ready,
    output inst_ready, alu_op_valid, alu_elem_idx, flag_alu_rst, flag_operand,
           flag_operation, busy, fifo_count, err_illegal
  );

  modport master (
    output inst_valid, inst_data, alu_ready,
    input  inst_ready, alu_op_valid, alu_elem_idx, flag_alu_rst, flag_operand,
           flag_operation, busy, fifo_count, err_illegal
  );
endinterface

// File: rtl/vau_sync_fifo.sv
// Single-clock FIFO; DEPTH must be a power of two so pointers wrap by overflow.
module vau_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                       clock,
  input  logic                       resetb,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_wr_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push    = i_push && !o_full;
  assign w_pop     = i_pop && !o_empty;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/vau_inst_sequencer.sv
// Buffers host vector instructions and steps the ALU through reset / load A / load B / execute.
//   state  | meaning
//   IDLE   | waiting for a buffered instruction (pop on exit)
//   DECODE | classify latched opcode / vlen
//   RST    | hold flag_alu_rst for RST_CYCLES cycles
//   LOAD_A | request elements 0..vlen-1, operand A
//   LOAD_B | request elements 0..vlen-1, operand B
//   EXEC   | request elements 0..vlen-1, execute
module vau_inst_sequencer
  import vau_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int VLEN_W     = 8,
  parameter int RST_CYCLES = 2
) (
  input  logic                 clock,
  input  logic                 resetb,
  vau_inst_sequencer_if.slave  bus
);
  localparam logic [7:0] RST_LOAD = 8'(RST_CYCLES - 1);

  logic [INST_KEEP_W-1:0]       w_fifo_rd;
  logic                         w_full;
  logic                         w_empty;
  logic                         w_pop;
  logic [$clog2(FIFO_DEPTH):0]  w_count;
  logic [3:0]                   w_rd_op;
  logic [7:0]                   w_rd_vlen;
  logic                         w_accept;
  logic                         w_last;
  logic                         w_unused_rsvd;

  logic [2:0]        r_state;
  logic [3:0]        r_op;
  logic [VLEN_W-1:0] r_vlen;
  logic [VLEN_W-1:0] r_idx;
  logic [7:0]        r_rst_cnt;
  logic              r_flag_rst;
  logic              r_flag_operand;
  logic [3:0]        r_flag_op;
  logic              r_err;

  assign w_unused_rsvd = ^bus.inst_data[VLEN_LSB-1:0];

  vau_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INST_KEEP_W)) u_fifo (
    .clock     (clock),
    .resetb    (resetb),
    .i_push    (bus.inst_valid),
    .i_wr_data (bus.inst_data[OPC_MSB:VLEN_LSB]),
    .i_pop     (w_pop),
    .o_rd_data (w_fifo_rd),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count)
  );

  assign w_rd_op   = w_fifo_rd[INST_KEEP_W-1 -: 4];
  assign w_rd_vlen = w_fifo_rd[7:0];
  assign w_pop     = (r_state == ST_IDLE) && !w_empty;
  assign w_accept  = bus.alu_op_valid && bus.alu_ready;
  assign w_last    = (r_idx == r_vlen - VLEN_W'(1));

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_NOP;
      r_vlen         <= '0;
      r_idx          <= '0;
      r_rst_cnt      <= '0;
      r_flag_rst     <= 1'b0;
      r_flag_operand <= 1'b0;
      r_flag_op      <= 4'h0;
      r_err          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            r_state <= ST_DECODE;
            r_op    <= w_rd_op;
            r_vlen  <= VLEN_W'(w_rd_vlen);
          end
        end
        ST_DECODE: begin
          if (r_op == OP_RESET) begin
            r_state    <= ST_RST;
            r_flag_rst <= 1'b1;
            r_rst_cnt  <= RST_LOAD;
          end else if (is_alu_op(r_op) && (r_vlen != '0)) begin
            r_state        <= ST_LOAD_A;
            r_flag_op      <= r_op;
            r_flag_operand <= 1'b0;
            r_idx          <= '0;
          end else begin
            r_state <= ST_IDLE;
            if ((r_op != OP_NOP) && !is_alu_op(r_op)) r_err <= 1'b1;
          end
        end
        ST_RST: begin
          if (r_rst_cnt == '0) begin
            r_state    <= ST_IDLE;
            r_flag_rst <= 1'b0;
            r_flag_op  <= 4'h0;
          end else begin
            r_rst_cnt <= r_rst_cnt - 8'd1;
          end
        end
        ST_LOAD_A, ST_LOAD_B, ST_EXEC: begin
          if (w_accept) begin
            if (w_last) begin
              r_idx <= '0;
              if (r_state == ST_LOAD_A) begin
                r_state        <= ST_LOAD_B;
                r_flag_operand <= 1'b1;
              end else if (r_state == ST_LOAD_B) begin
                r_state <= ST_EXEC;
              end else begin
                r_state        <= ST_IDLE;
                r_flag_operand <= 1'b0;
              end
            end else begin
              r_idx <= r_idx + VLEN_W'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.inst_ready     = !w_full;
  assign bus.alu_op_valid   = (r_state == ST_LOAD_A) || (r_state == ST_LOAD_B) ||
                              (r_state == ST_EXEC);
  assign bus.alu_elem_idx   = r_idx;
  assign bus.flag_alu_rst   = r_flag_rst;
  assign bus.flag_operand   = r_flag_operand;
  assign bus.flag_operation = r_flag_op;
  assign bus.busy           = (r_state != ST_IDLE) || !w_empty;
  assign bus.fifo_count     = w_count;
  assign bus.err_illegal    = r_err;
endmodule

// File: tb/tb_vau_inst_sequencer.sv
// Scoreboard bench: stimulus queues expected ALU requests, a negedge monitor checks each accept.
module tb_vau_inst_sequencer;
  logic clk = 1'b0;
  logic resetb = 1'b0;
  always #5 clk = ~clk;

  vau_inst_sequencer_if #(.FIFO_DEPTH(4), .VLEN_W(8)) bus ();

  vau_inst_sequencer #(.FIFO_DEPTH(4), .VLEN_W(8), .RST_CYCLES(2)) dut (
    .clock  (clk),
    .resetb (resetb),
    .bus    (bus)
  );

  typedef struct {
    logic [3:0] op;
    logic       operand;
    logic [7:0] idx;
  } req_t;

  req_t       exp_q[$];
  req_t       mon_e;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_accept = 0;
  int         ready_mode = 0;
  logic       ready_val = 1'b0;
  int         rcyc = 0;
  logic       hold_pend = 1'b0;
  logic [7:0] held_idx = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic expect_inst(input logic [3:0] op, input int vlen);
    req_t e;
    for (int ph = 0; ph < 3; ph++)
      for (int i = 0; i < vlen; i++) begin
        e.op = op; e.operand = (ph != 0); e.idx = 8'(i);
        exp_q.push_back(e);
      end
  endtask

  task automatic push(input logic [31:0] d);
    bus.inst_valid = 1'b1;
    bus.inst_data  = d;
    @(posedge clk); #1;
    bus.inst_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin @(posedge clk); #1; n++; end while (bus.busy && n < budget);
    chk("idle_timeout_busy", bus.busy, 0);
    chk("sb_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_inst_ready", bus.inst_ready, 1);
    chk("rst_alu_op_valid", bus.alu_op_valid, 0);
    chk("rst_elem_idx", bus.alu_elem_idx, 0);
    chk("rst_flag_alu_rst", bus.flag_alu_rst, 0);
    chk("rst_flag_operand", bus.flag_operand, 0);
    chk("rst_flag_operation", bus.flag_operation, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fifo_count", bus.fifo_count, 0);
    chk("rst_err_illegal", bus.err_illegal, 0);
  endtask

  // ALU ready driver: constant level or one accept slot in every three cycles.
  initial bus.alu_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    rcyc++;
    bus.alu_ready = (ready_mode == 1) ? (rcyc % 3 == 0) : ready_val;
  end

  always @(negedge clk) begin
    if (!resetb) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        chk("hold_valid", bus.alu_op_valid, 1);
        chk("hold_idx", bus.alu_elem_idx, held_idx);
      end
      if (bus.alu_op_valid) begin
        if (bus.alu_ready) begin
          hold_pend = 1'b0;
          n_accept++;
          chk("sb_expected_accept", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("req_idx", bus.alu_elem_idx, mon_e.idx);
            chk("req_operand", bus.flag_operand, mon_e.operand);
            chk("req_operation", bus.flag_operation, mon_e.op);
          end
        end else begin
          hold_pend = 1'b1;
          held_idx  = bus.alu_elem_idx;
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, hi_cnt, v_cnt;
    bus.inst_valid = 1'b0;
    bus.inst_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk) resetb = 1'b1;
    @(posedge clk); #1;

    // ALU op 3, vlen 4, ready always high; latency and phase flags.
    ready_mode = 0; ready_val = 1'b1;
    @(posedge clk); #1;
    a0 = n_accept;
    expect_inst(4'h3, 4);
    push(32'h3040_0000);
    chk("t1_valid_push_cycle", bus.alu_op_valid, 0);
    chk("t1_fifo_count", bus.fifo_count, 1);
    @(posedge clk); #1;
    chk("t1_valid_decode", bus.alu_op_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid_latency2", bus.alu_op_valid, 1);
    chk("t1_flag_operation", bus.flag_operation, 3);
    chk("t1_flag_operand", bus.flag_operand, 0);
    wait_idle(100);
    chk("t1_accepts", n_accept - a0, 12);
    chk("t1_operand_after", bus.flag_operand, 0);
    chk("t1_operation_held", bus.flag_operation, 3);

    // Backpressure: ready one cycle in three.
    ready_mode = 1;
    a0 = n_accept;
    expect_inst(4'h3, 4);
    push(32'h3040_0000);
    wait_idle(300);
    chk("t2_accepts", n_accept - a0, 12);
    chk("t2_operation_held", bus.flag_operation, 3);

    // RESET instruction: flag_alu_rst high for exactly two cycles.
    ready_mode = 0; ready_val = 1'b1;
    push(32'hF000_0000);
    hi_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus.flag_alu_rst) hi_cnt++;
    end
    chk("t3_rst_cycles", hi_cnt, 2);
    chk("t3_operation_cleared", bus.flag_operation, 0);
    chk("t3_busy", bus.busy, 0);

    // FIFO fill: first instruction stalls in LOAD_A, then six pushes, last two dropped.
    ready_val = 1'b0;
    a0 = n_accept;
    expect_inst(4'h1, 2);
    push(32'h1020_0000);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_stalled_valid", bus.alu_op_valid, 1);
    chk("t4_fifo_empty", bus.fifo_count, 0);
    begin
      logic [31:0] words [6];
      int          vl [6];
      words = '{32'h2010_0000, 32'h4030_0000, 32'h5010_0000, 32'h6020_0000,
                32'h7050_0000, 32'hA050_0000};
      vl    = '{1, 3, 1, 2, 5, 5};
      for (int i = 0; i < 6; i++) begin
        chk("t4_inst_ready", bus.inst_ready, (i < 4) ? 1 : 0);
        if (i < 4) expect_inst(words[i][31:28], vl[i]);
        push(words[i]);
      end
    end
    chk("t4_fifo_full_count", bus.fifo_count, 4);
    chk("t4_inst_ready_full", bus.inst_ready, 0);
    ready_val = 1'b1;
    wait_idle(400);
    chk("t4_accepts", n_accept - a0, 27);
    chk("t4_fifo_drained", bus.fifo_count, 0);

    // Illegal, NOP and zero-length ALU op: no requests, sticky error.
    chk("t5_err_before", bus.err_illegal, 0);
    a0 = n_accept;
    push(32'hC000_0000);
    push(32'h0000_0000);
    push(32'h2000_0000);
    v_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.alu_op_valid) v_cnt++;
    end
    chk("t5_no_valid", v_cnt, 0);
    chk("t5_no_accepts", n_accept - a0, 0);
    chk("t5_err_illegal", bus.err_illegal, 1);
    chk("t5_fifo_drained", bus.fifo_count, 0);
    chk("t5_busy", bus.busy, 0);

    // Reset asserted while EXEC presents idx 3.
    a0 = n_accept;
    expect_inst(4'h5, 8);
    push(32'h5080_0000);
    v_cnt = 0;
    while ((n_accept - a0) < 19 && v_cnt < 200) begin
      @(posedge clk); #1;
      v_cnt++;
    end
    chk("t6_reached_exec", n_accept - a0, 19);
    chk("t6_exec_idx", bus.alu_elem_idx, 3);
    chk("t6_exec_operand", bus.flag_operand, 1);
    resetb = 1'b0;
    #1;
    check_reset_outputs();
    exp_q.delete();
    a0 = n_accept;
    v_cnt = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (bus.alu_op_valid) v_cnt++;
    end
    @(negedge clk) resetb = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.alu_op_valid) v_cnt++;
    end
    chk("t6_no_valid_after_reset", v_cnt, 0);
    chk("t6_no_accepts_after_reset", n_accept - a0, 0);
    chk("t6_busy_after_reset", bus.busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
